mem_access_unit: RTL and testbench

//  Memory-side stage of the multicycle RV32I core: turns the control unit's single-cycle fetch/load/store

---
 rtl/mem_access_pkg.sv | 14 +
 rtl/lsu_align.sv | 58 +++++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and constants for the memory access stage
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering: store enables/replication, alignment check, load extension
module lsu_align
  import mem_access_pkg::*;
(
  input  logic        fetch,
  input  logic        store,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        misalign,
  input  logic [31:0] raw,
  input  logic [1:0]  ld_offset,
  input  logic [2:0]  ld_funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Fetches and word-sized (including unknown funct3) accesses must be word aligned.
  always_comb begin
    be         = 4'hF;
    wdata_lane = wdata;
    misalign   = (offset != 2'b00);
    if (!fetch) begin
      case (funct3)
        F3_B, F3_BU: begin
          misalign   = 1'b0;
          wdata_lane = {4{wdata[7:0]}};
          if (store) be = 4'b0001 << offset;
        end
        F3_H, F3_HU: begin
          misalign   = offset[0];
          wdata_lane = {2{wdata[15:0]}};
          if (store) be = offset[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  assign byte_v = raw[{ld_offset, 3'b000} +: 8];
  assign half_v = raw[{ld_offset[1], 4'b0000} +: 16];

  always_comb begin
    case (ld_funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data = {24'h0, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data = {16'h0, half_v};
      F3_W:    load_data = raw;
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - fetch/load/store handshake stage toward a variable-latency memory
// Optional REQ watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        addr_sel,
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc,
  input  logic [31:0] data_addr,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] instr,
  output logic [31:0] old_pc,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic        sel_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] raw;
  logic [31:0] addr;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        misalign;

  assign addr  = addr_sel ? data_addr : pc;
  assign stall = start | (state == REQ);

  lsu_align u_align (
    .fetch      (!addr_sel),
    .store      (addr_sel & write),
    .offset     (addr[1:0]),
    .funct3     (funct3),
    .wdata      (write_data),
    .be         (be_next),
    .wdata_lane (wdata_next),
    .misalign   (misalign),
    .raw        (raw),
    .ld_offset  (off_q),
    .ld_funct3  (f3_q),
    .load_data  (load_data)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [31:0] wait_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      sel_q      <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      raw        <= 32'h0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
      instr      <= NOP_INSTR;
      old_pc     <= RESET_PC;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_be     <= 4'h0;
      mem_wdata  <= 32'h0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      wait_cnt   <= 32'h0;
`endif
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (misalign) begin
              state      <= ERR;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state     <= REQ;
              sel_q     <= addr_sel;
              f3_q      <= funct3;
              off_q     <= addr[1:0];
              mem_req   <= 1'b1;
              mem_we    <= addr_sel & write;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
`ifdef MEM_ACCESS_TIMEOUT_EN
              wait_cnt  <= 32'h0;
`endif
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            state   <= DONE;
            done    <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            // Fetch address is word aligned, so mem_addr is exactly the pc that was fetched.
            if (!sel_q) begin
              instr  <= mem_rdata;
              old_pc <= mem_addr;
            end else if (!mem_we) begin
              raw <= mem_rdata;
            end
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_CYCLES - 1) begin
            state   <= ERR;
            done    <= 1'b1;
            timeout <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 32'h1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int unsigned T_CYC = 4;
  localparam logic [31:0] RPC   = 32'h0000_1000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0, addr_sel = 1'b0, write = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] pc = 32'h0, data_addr = 32'h0, write_data = 32'h0;
  logic        stall, done, misaligned, timeout, mem_req, mem_we;
  logic [31:0] instr, old_pc, load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_fails  = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(T_CYC), .RESET_PC(RPC)) dut (
    .clock(clock), .resetn(resetn), .start(start), .addr_sel(addr_sel), .write(write),
    .funct3(funct3), .pc(pc), .data_addr(data_addr), .write_data(write_data),
    .stall(stall), .done(done), .instr(instr), .old_pc(old_pc), .load_data(load_data),
    .misaligned(misaligned), .timeout(timeout), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Reference model state and observations of the last access
  logic [31:0] exp_instr = NOP, exp_old_pc = RPC;
  logic        o_stall_start, o_req_seen, o_stable, o_got, o_mis, o_to, o_req_done, o_stall_done;
  logic        f_req, f_we;
  logic [31:0] f_addr, f_wdata, o_instr, o_old_pc, o_load;
  logic [3:0]  f_be;
  int          o_latency, o_dones;

  function automatic int size_of(input logic sel, input logic [2:0] f3);
    if (!sel) return 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic sel, input logic wr, input logic [2:0] f3,
                                          input logic [31:0] a);
    int n;
    if (!(sel && wr)) return 4'hF;
    n = size_of(sel, f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n;
    n = size_of(1'b1, f3);
    if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    case (f3)
      3'd0:    return (v & 32'hFF) - ((v & 32'h80) != 0 ? 32'h100 : 32'h0);
      3'd4:    return v & 32'hFF;
      3'd1:    return (v & 32'hFFFF) - ((v & 32'h8000) != 0 ? 32'h1_0000 : 32'h0);
      3'd5:    return v & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [2:0] rand_f3();
    logic [2:0] tbl [8];
    tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    return tbl[$urandom_range(0, 7)];
  endfunction

  // Drives one access and records what the DUT did; the test tasks judge it.
  task automatic run_access(input logic sel, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input int lat,
                            input logic [31:0] rd, input bit poke);
    int k;
    addr_sel = sel; write = wr; funct3 = f3; write_data = wd;
    if (sel) begin data_addr = a; pc = $urandom; end
    else begin pc = a; data_addr = $urandom; end
    start = 1'b1;
    #1 o_stall_start = stall;
    @(negedge clock);
    start = 1'b0;
    f_req = mem_req; f_we = mem_we; f_addr = mem_addr; f_be = mem_be; f_wdata = mem_wdata;
    o_req_seen = mem_req; o_stable = 1'b1; o_got = 1'b0; k = 0;
    while (!o_got && k < 400) begin
      if (done) begin
        o_got = 1'b1;
      end else begin
        o_req_seen |= mem_req;
        if (mem_req !== 1'b1 || mem_we !== f_we || mem_addr !== f_addr || mem_be !== f_be ||
            mem_wdata !== f_wdata || stall !== 1'b1) o_stable = 1'b0;
        if (k == lat) begin mem_ready = 1'b1; mem_rdata = rd; end
        if (poke && k == 0) start = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0; start = 1'b0; mem_rdata = $urandom;
        k++;
      end
    end
    o_latency = o_got ? k + 1 : -1;
    o_mis = misaligned; o_to = timeout; o_instr = instr; o_old_pc = old_pc; o_load = load_data;
    o_req_done = mem_req; o_stall_done = stall; o_dones = o_got ? 1 : 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      o_req_seen |= mem_req;
      if (done) o_dones++;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (stall !== 1'b0 || done !== 1'b0 || misaligned !== 1'b0 || timeout !== 1'b0) begin
      n_fails++; $display("FAIL reset_flags: stall=%b done=%b mis=%b to=%b, required all 0", stall, done, misaligned, timeout); end
    n_checks++; if (instr !== NOP || old_pc !== RPC) begin
      n_fails++; $display("FAIL reset_ir: instr=%h old_pc=%h, required %h %h", instr, old_pc, NOP, RPC); end
    n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 ||
                    mem_wdata !== 32'h0 || load_data !== 32'h0) begin
      n_fails++; $display("FAIL reset_bus: req=%b we=%b addr=%h be=%h wd=%h ld=%h, required all 0",
                          mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data); end
  endtask

  task automatic test_fetch();
    logic [31:0] a, rd;
    for (int i = 0; i < 6; i++) begin
      int lat;
      a   = (i == 0) ? 32'h40 : ($urandom & 32'hFFFF_FFFC);
      rd  = (i == 0) ? 32'h0050_0093 : $urandom;
      lat = (i == 0) ? 3 : $urandom_range(0, 5);
      run_access(1'b0, $urandom_range(0, 1) == 1, rand_f3(), a, $urandom, lat, rd, 1'b0);
      exp_instr = rd; exp_old_pc = a;
      n_checks++; if (o_instr !== exp_instr || o_old_pc !== exp_old_pc) begin
        n_fails++; $display("FAIL fetch_ir[%0d]: instr=%h old_pc=%h, required %h %h", i, o_instr, o_old_pc, exp_instr, exp_old_pc); end
      n_checks++; if (o_latency !== lat + 2 || o_dones !== 1 || o_mis !== 1'b0) begin
        n_fails++; $display("FAIL fetch_done[%0d]: latency=%0d pulses=%0d mis=%b, required %0d 1 0", i, o_latency, o_dones, o_mis, lat + 2); end
      n_checks++; if (f_req !== 1'b1 || f_we !== 1'b0 || f_addr !== a || f_be !== 4'hF || !o_stable) begin
        n_fails++; $display("FAIL fetch_bus[%0d]: req=%b we=%b addr=%h be=%h stable=%b, required 1 0 %h f 1", i, f_req, f_we, f_addr, f_be, o_stable, a); end
      n_checks++; if (o_stall_start !== 1'b1 || o_stall_done !== 1'b0 || o_req_done !== 1'b0) begin
        n_fails++; $display("FAIL fetch_stall[%0d]: stall_start=%b stall_done=%b req_done=%b, required 1 0 0", i, o_stall_start, o_stall_done, o_req_done); end
    end
  endtask

  task automatic test_load();
    logic [31:0] a, rd;
    logic [2:0]  f3;
    for (int i = 0; i < 24; i++) begin
      int lat;
      f3  = (i == 0) ? 3'd0 : (i == 1) ? 3'd4 : rand_f3();
      a   = (i < 2) ? 32'h103 : $urandom;
      a   = a - (a % size_of(1'b1, f3));
      rd  = (i < 2) ? 32'h80FF_1234 : $urandom;
      lat = $urandom_range(0, 4);
      run_access(1'b1, 1'b0, f3, a, $urandom, lat, rd, 1'b0);
      n_checks++; if (o_load !== model_load(f3, a, rd)) begin
        n_fails++; $display("FAIL load_data[%0d]: f3=%0d addr=%h raw=%h got %h, required %h", i, f3, a, rd, o_load, model_load(f3, a, rd)); end
      n_checks++; if (f_addr !== (a & 32'hFFFF_FFFC) || f_be !== 4'hF || f_we !== 1'b0 || !o_stable || o_latency !== lat + 2) begin
        n_fails++; $display("FAIL load_bus[%0d]: addr=%h be=%h we=%b stable=%b lat=%0d, required %h f 0 1 %0d",
                            i, f_addr, f_be, f_we, o_stable, o_latency, a & 32'hFFFF_FFFC, lat + 2); end
      n_checks++; if (o_instr !== exp_instr || o_old_pc !== exp_old_pc) begin
        n_fails++; $display("FAIL load_keeps_ir[%0d]: instr=%h old_pc=%h, required %h %h", i, o_instr, o_old_pc, exp_instr, exp_old_pc); end
    end
  endtask

  task automatic test_store();
    logic [31:0] a, wd;
    logic [2:0]  f3;
    for (int i = 0; i < 20; i++) begin
      int lat;
      f3  = (i == 0) ? 3'd1 : rand_f3();
      a   = (i == 0) ? 32'h202 : $urandom;
      a   = a - (a % size_of(1'b1, f3));
      wd  = (i == 0) ? 32'h0000_BEEF : $urandom;
      lat = (i == 0) ? 4 : $urandom_range(0, 4);
      run_access(1'b1, 1'b1, f3, a, wd, lat, $urandom, 1'b0);
      n_checks++; if (f_be !== model_be(1'b1, 1'b1, f3, a) || f_wdata !== model_wdata(f3, wd)) begin
        n_fails++; $display("FAIL store_lanes[%0d]: f3=%0d addr=%h be=%b wdata=%h, required %b %h",
                            i, f3, a, f_be, f_wdata, model_be(1'b1, 1'b1, f3, a), model_wdata(f3, wd)); end
      n_checks++; if (f_req !== 1'b1 || f_we !== 1'b1 || f_addr !== (a & 32'hFFFF_FFFC) || !o_stable || o_latency !== lat + 2 || o_dones !== 1) begin
        n_fails++; $display("FAIL store_bus[%0d]: req=%b we=%b addr=%h stable=%b lat=%0d pulses=%0d, required 1 1 %h 1 %0d 1",
                            i, f_req, f_we, f_addr, o_stable, o_latency, o_dones, a & 32'hFFFF_FFFC, lat + 2); end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] a;
    logic [2:0]  f3;
    logic        sel;
    for (int i = 0; i < 12; i++) begin
      sel = (i == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      f3  = (i == 0) ? 3'd2 : ($urandom_range(0, 1) ? 3'd1 : 3'd2);
      a   = (i == 0) ? 32'h101 : $urandom;
      if (a % size_of(sel, f3) == 0) a = a | 32'h1;
      run_access(sel, $urandom_range(0, 1) == 1, f3, a, $urandom, 0, $urandom, 1'b0);
      n_checks++; if (o_latency !== 1 || o_mis !== 1'b1 || o_to !== 1'b0 || o_dones !== 1) begin
        n_fails++; $display("FAIL misalign_err[%0d]: latency=%0d mis=%b to=%b pulses=%0d, required 1 1 0 1", i, o_latency, o_mis, o_to, o_dones); end
      n_checks++; if (o_req_seen !== 1'b0 || o_instr !== exp_instr) begin
        n_fails++; $display("FAIL misalign_quiet[%0d]: req_seen=%b instr=%h, required 0 %h", i, o_req_seen, o_instr, exp_instr); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, rd;
    for (int i = 0; i < 4; i++) begin
      a  = $urandom & 32'hFFFF_FFFC;
      rd = $urandom;
      run_access(1'b1, 1'b0, 3'd2, a, $urandom, $urandom_range(1, 4), rd, 1'b1);
      n_checks++; if (o_dones !== 1 || o_load !== rd) begin
        n_fails++; $display("FAIL start_in_req[%0d]: pulses=%0d load=%h, required 1 %h", i, o_dones, o_load, rd); end
    end
  endtask

  task automatic test_reset_mid_req();
    addr_sel = 1'b0; write = 1'b0; pc = 32'h0000_0200; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    n_checks++; if (mem_req !== 1'b1) begin
      n_fails++; $display("FAIL midreq_pending: mem_req=%b, required 1", mem_req); end
    resetn = 1'b0;
    @(negedge clock);
    n_checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || instr !== NOP) begin
      n_fails++; $display("FAIL midreq_reset: req=%b stall=%b done=%b instr=%h, required 0 0 0 %h", mem_req, stall, done, instr, NOP); end
    resetn = 1'b1;
    exp_instr = NOP; exp_old_pc = RPC;
    @(negedge clock);
    run_access(1'b0, 1'b0, 3'd2, 32'h0000_0300, 32'h0, 1, 32'h1234_5678, 1'b0);
    exp_instr = 32'h1234_5678; exp_old_pc = 32'h0000_0300;
    n_checks++; if (o_instr !== exp_instr || o_old_pc !== exp_old_pc || o_latency !== 3) begin
      n_fails++; $display("FAIL midreq_recover: instr=%h old_pc=%h lat=%0d, required %h %h 3", o_instr, o_old_pc, o_latency, exp_instr, exp_old_pc); end
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    run_access(1'b0, 1'b0, 3'd2, 32'h0000_0500, 32'h0, 1000, 32'hDEAD_BEEF, 1'b0);
    n_checks++; if (o_latency !== int'(T_CYC) + 1 || o_to !== 1'b1 || o_mis !== 1'b0 || o_dones !== 1) begin
      n_fails++; $display("FAIL timeout_abort: lat=%0d to=%b mis=%b pulses=%0d, required %0d 1 0 1", o_latency, o_to, o_mis, o_dones, T_CYC + 1); end
    n_checks++; if (o_req_done !== 1'b0 || o_instr !== exp_instr || o_old_pc !== exp_old_pc) begin
      n_fails++; $display("FAIL timeout_state: req=%b instr=%h old_pc=%h, required 0 %h %h", o_req_done, o_instr, o_old_pc, exp_instr, exp_old_pc); end
  endtask
`else
  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'd2, 32'h0000_0600, 32'h0, 40, 32'hCAFE_F00D, 1'b0);
    n_checks++; if (o_latency !== 42 || o_to !== 1'b0 || o_load !== 32'hCAFE_F00D || !o_stable) begin
      n_fails++; $display("FAIL long_wait: lat=%0d to=%b load=%h stable=%b, required 42 0 cafef00d 1", o_latency, o_to, o_load, o_stable); end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    test_reset();
    @(negedge clock);
    test_fetch();
    test_load();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_req();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
